// File: rtl/fifo_async_pkg.sv
// Shared types, constants and reflected-Gray pointer helpers for fifo_async_thresh.
package fifo_async_pkg;

  localparam int unsigned SyncStages = 2;
  localparam int unsigned MaxPtrW    = 32;

  typedef logic [MaxPtrW-1:0] ptr_vec_t;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_async_err_t;

  // The MSB=1 half walks the Gray sequence backwards, so both wraps toggle only the MSB.
  function automatic ptr_vec_t dec2gray(input int unsigned depth, input ptr_vec_t bin);
    int unsigned lw;
    ptr_vec_t    mask;
    ptr_vec_t    low;
    ptr_vec_t    v;
    logic        msb;
    lw   = $clog2(depth);
    mask = (ptr_vec_t'(1) << lw) - ptr_vec_t'(1);
    low  = bin & mask;
    msb  = ((bin >> lw) & ptr_vec_t'(1)) != '0;
    if (msb) begin
      v = ptr_vec_t'(depth - 1) - low;
      return (v ^ (v >> 1)) | (ptr_vec_t'(1) << lw);
    end
    return low ^ (low >> 1);
  endfunction

  function automatic ptr_vec_t gray2dec(input int unsigned depth, input ptr_vec_t gray);
    int unsigned lw;
    ptr_vec_t    mask;
    ptr_vec_t    gl;
    ptr_vec_t    v;
    logic        msb;
    lw   = $clog2(depth);
    mask = (ptr_vec_t'(1) << lw) - ptr_vec_t'(1);
    gl   = gray & mask;
    msb  = ((gray >> lw) & ptr_vec_t'(1)) != '0;
    v    = '0;
    for (int unsigned i = 0; i < MaxPtrW; i++) begin
      v = v ^ (gl >> i);
    end
    if (msb) begin
      v = (ptr_vec_t'(depth - 1) - v) | (ptr_vec_t'(1) << lw);
    end
    return v;
  endfunction

endpackage

// File: rtl/fifo_async_ptr.sv
// Binary + registered reflected-Gray pointer for one FIFO clock domain; wraps at Depth.
module fifo_async_ptr
  import fifo_async_pkg::*;
#(
  parameter  int unsigned Depth = 4,
  localparam int unsigned LowW  = $clog2(Depth),
  localparam int unsigned PtrW  = LowW + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            inc_i,
  output logic [PtrW-1:0] bin_o,
  output logic [PtrW-1:0] gray_o,
  output logic [LowW-1:0] low_o
);

  logic [PtrW-1:0] bin_q;
  logic [PtrW-1:0] bin_d;
  logic [PtrW-1:0] gray_q;

  always_comb begin
    bin_d = bin_q;
    if (inc_i) begin
      if (bin_q[LowW-1:0] == LowW'(Depth - 1)) begin
        bin_d = {~bin_q[PtrW-1], LowW'(0)};
      end else begin
        bin_d = bin_q + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bin_q  <= '0;
      gray_q <= '0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= PtrW'(dec2gray(Depth, ptr_vec_t'(bin_d)));
    end
  end

  assign bin_o  = bin_q;
  assign gray_o = gray_q;
  assign low_o  = bin_q[LowW-1:0];

endmodule

// File: rtl/fifo_async_thresh.sv
// Dual-clock FIFO (any Depth >= 2) with almost-full/almost-empty thresholds and sticky errors.
// Optional read-side output register: define FIFO_ASYNC_THRESH_OUTREG_EN.
module fifo_async_thresh
  import fifo_async_pkg::*;
#(
  parameter  int unsigned Width  = 16,
  parameter  int unsigned Depth  = 4,
  localparam int unsigned DepthW = $clog2(Depth + 1)
) (
  input  logic              clk_wr_i,
  input  logic              rst_wr_ni,
  input  logic              clk_rd_i,
  input  logic              rst_rd_ni,
  input  logic              wvalid_i,
  output logic              wready_o,
  input  logic [Width-1:0]  wdata_i,
  output logic [DepthW-1:0] wdepth_o,
  input  logic [DepthW-1:0] afull_thresh_i,
  output logic              walmost_full_o,
  output logic              woverflow_o,
  output logic              rvalid_o,
  input  logic              rready_i,
  output logic [Width-1:0]  rdata_o,
  output logic [DepthW-1:0] rdepth_o,
  input  logic [DepthW-1:0] aempty_thresh_i,
  output logic              ralmost_empty_o,
  output logic              runderflow_o
);

  localparam int unsigned LowW = $clog2(Depth);
  localparam int unsigned PtrW = LowW + 1;

  if (Depth < 2) begin : g_chk_depth
    $error("fifo_async_thresh: Depth must be >= 2");
  end
  if (Width < 1) begin : g_chk_width
    $error("fifo_async_thresh: Width must be >= 1");
  end

  function automatic logic [DepthW-1:0] occupancy(input logic [PtrW-1:0] w,
                                                   input logic [PtrW-1:0] r);
    if (w == {~r[PtrW-1], r[LowW-1:0]}) return DepthW'(Depth);
    if (w[PtrW-1] == r[PtrW-1]) return DepthW'(w[LowW-1:0]) - DepthW'(r[LowW-1:0]);
    return DepthW'(Depth) - DepthW'(r[LowW-1:0]) + DepthW'(w[LowW-1:0]);
  endfunction

  logic [Width-1:0] mem [Depth];

  // Write domain
  logic                            wr_en;
  logic                            wfull;
  logic [PtrW-1:0]                 wptr;
  logic [PtrW-1:0]                 wptr_gray;
  logic [LowW-1:0]                 wptr_low;
  logic [PtrW-1:0]                 rptr_sync_w;
  logic [SyncStages-1:0][PtrW-1:0] rgray_sync;
  logic                            walmost_full_q;
  logic                            woverflow_q;

  // Read domain
  logic                            rd_pop;
  logic                            fifo_rvalid;
  logic [PtrW-1:0]                 rptr;
  logic [PtrW-1:0]                 rptr_gray;
  logic [LowW-1:0]                 rptr_low;
  logic [PtrW-1:0]                 wptr_sync_r;
  logic [SyncStages-1:0][PtrW-1:0] wgray_sync;
  logic [DepthW-1:0]               fifo_rdepth;
  logic                            ralmost_empty_q;
  logic                            runderflow_q;
  fifo_async_err_t                 err;

  fifo_async_ptr #(.Depth(Depth)) u_wptr (
    .clk_i  (clk_wr_i),
    .rst_ni (rst_wr_ni),
    .inc_i  (wr_en),
    .bin_o  (wptr),
    .gray_o (wptr_gray),
    .low_o  (wptr_low)
  );

  assign wfull    = (wptr == {~rptr_sync_w[PtrW-1], rptr_sync_w[LowW-1:0]});
  assign wready_o = ~wfull;
  assign wr_en    = wvalid_i & ~wfull;
  assign wdepth_o = occupancy(wptr, rptr_sync_w);

  always_ff @(posedge clk_wr_i or negedge rst_wr_ni) begin
    if (!rst_wr_ni) begin
      rgray_sync     <= '0;
      rptr_sync_w    <= '0;
      walmost_full_q <= 1'b0;
      woverflow_q    <= 1'b0;
    end else begin
      rgray_sync     <= {rgray_sync[SyncStages-2:0], rptr_gray};
      rptr_sync_w    <= PtrW'(gray2dec(Depth, ptr_vec_t'(rgray_sync[SyncStages-1])));
      walmost_full_q <= (wdepth_o >= afull_thresh_i);
      woverflow_q    <= woverflow_q | (wvalid_i & wfull);
    end
  end

  always_ff @(posedge clk_wr_i) begin
    if (wr_en) mem[wptr_low] <= wdata_i;
  end

  fifo_async_ptr #(.Depth(Depth)) u_rptr (
    .clk_i  (clk_rd_i),
    .rst_ni (rst_rd_ni),
    .inc_i  (rd_pop),
    .bin_o  (rptr),
    .gray_o (rptr_gray),
    .low_o  (rptr_low)
  );

  assign wptr_sync_r = PtrW'(gray2dec(Depth, ptr_vec_t'(wgray_sync[SyncStages-1])));
  assign fifo_rvalid = (wptr_sync_r != rptr);
  assign fifo_rdepth = occupancy(wptr_sync_r, rptr);

`ifdef FIFO_ASYNC_THRESH_OUTREG_EN
  logic             oreg_valid;
  logic [Width-1:0] oreg_data;
  logic [DepthW:0]  rdepth_sum;

  if (Depth + 1 > 2 ** DepthW) begin : g_chk_outreg
    $error("fifo_async_thresh: Depth+1 does not fit in DepthW bits");
  end

  // Prefetch the head whenever the register is empty or being drained this cycle.
  assign rd_pop = fifo_rvalid & (~oreg_valid | rready_i);

  always_ff @(posedge clk_rd_i or negedge rst_rd_ni) begin
    if (!rst_rd_ni) begin
      oreg_valid <= 1'b0;
    end else if (rd_pop) begin
      oreg_valid <= 1'b1;
    end else if (rready_i) begin
      oreg_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_rd_i) begin
    if (rd_pop) oreg_data <= mem[rptr_low];
  end

  assign rvalid_o   = oreg_valid;
  assign rdata_o    = oreg_data;
  assign rdepth_sum = {1'b0, fifo_rdepth} + (DepthW + 1)'(oreg_valid);
  assign rdepth_o   = rdepth_sum[DepthW] ? '1 : rdepth_sum[DepthW-1:0];
`else
  assign rd_pop   = fifo_rvalid & rready_i;
  assign rvalid_o = fifo_rvalid;
  assign rdata_o  = mem[rptr_low];
  assign rdepth_o = fifo_rdepth;
`endif

  always_ff @(posedge clk_rd_i or negedge rst_rd_ni) begin
    if (!rst_rd_ni) begin
      wgray_sync      <= '0;
      ralmost_empty_q <= 1'b1;
      runderflow_q    <= 1'b0;
    end else begin
      wgray_sync      <= {wgray_sync[SyncStages-2:0], wptr_gray};
      ralmost_empty_q <= (rdepth_o <= aempty_thresh_i);
      runderflow_q    <= runderflow_q | (rready_i & ~rvalid_o);
    end
  end

  assign err             = '{overflow: woverflow_q, underflow: runderflow_q};
  assign woverflow_o     = err.overflow;
  assign runderflow_o    = err.underflow;
  assign walmost_full_o  = walmost_full_q;
  assign ralmost_empty_o = ralmost_empty_q;

  rst_pair_wr_a: assert property (@(posedge clk_wr_i) rst_wr_ni == rst_rd_ni)
    else $error("fifo_async_thresh: write and read resets must be asserted together");
  rst_pair_rd_a: assert property (@(posedge clk_rd_i) rst_wr_ni == rst_rd_ni)
    else $error("fifo_async_thresh: write and read resets must be asserted together");

endmodule
